// File: rtl/pinmux_in_filter_if.sv
// Bundle of the pad-conditioning signals between the pad side (master) and
// pinmux_in_filter (slave).
interface pinmux_in_filter_if #(
  parameter int unsigned NMioPads = 32,
  parameter int unsigned FiltCntW = 4
);
  logic [NMioPads-1:0] mio_pad_i;
  logic [NMioPads-1:0] filt_en_i;
  logic [FiltCntW-1:0] filt_thresh_i;
  logic [NMioPads-1:0] status_clr_i;
  logic [NMioPads-1:0] mio_in_o;
  logic [NMioPads-1:0] edge_rise_o;
  logic [NMioPads-1:0] edge_fall_o;
  logic [NMioPads-1:0] status_o;
  logic                irq_o;

  modport master (
    output mio_pad_i, filt_en_i, filt_thresh_i, status_clr_i,
    input  mio_in_o, edge_rise_o, edge_fall_o, status_o, irq_o
  );

  modport slave (
    input  mio_pad_i, filt_en_i, filt_thresh_i, status_clr_i,
    output mio_in_o, edge_rise_o, edge_fall_o, status_o, irq_o
  );
endinterface

// File: rtl/pinmux_in_filter.sv
// Per-pad synchronizer, programmable glitch filter and edge detect feeding pinmux mio_in_i.
// Define PINMUX_IN_FILTER_STATUS_EN to add sticky edge status flops and an aggregate irq.
module pinmux_in_filter #(
  parameter int unsigned NMioPads   = 32,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FiltCntW   = 4,
  parameter logic        PadRstVal  = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pinmux_in_filter_if.slave   bus
);

  logic [NMioPads-1:0] sync_q [SyncStages];
  logic [NMioPads-1:0] sync;
  logic [NMioPads-1:0] filt_q;
  logic [NMioPads-1:0] filt_dly_q;
  logic [FiltCntW-1:0] cnt_q [NMioPads];

  // Plain flop chain: no logic between stages so the metastability window is
  // confined to the first flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= {NMioPads{PadRstVal}};
      end
    end else begin
      sync_q[0] <= bus.mio_pad_i;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SyncStages-1];

  // A new level is accepted once it has differed from filt for thresh+1
  // consecutive cycles; ">=" keeps a lowered threshold from stranding a count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q     <= {NMioPads{PadRstVal}};
      filt_dly_q <= {NMioPads{PadRstVal}};
      for (int k = 0; k < NMioPads; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      filt_dly_q <= filt_q;
      for (int k = 0; k < NMioPads; k++) begin
        if (!bus.filt_en_i[k]) begin
          filt_q[k] <= sync[k];
          cnt_q[k]  <= '0;
        end else if (sync[k] == filt_q[k]) begin
          cnt_q[k]  <= '0;
        end else if (cnt_q[k] >= bus.filt_thresh_i) begin
          filt_q[k] <= sync[k];
          cnt_q[k]  <= '0;
        end else begin
          cnt_q[k]  <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign bus.mio_in_o    = filt_q;
  assign bus.edge_rise_o = filt_q & ~filt_dly_q;
  assign bus.edge_fall_o = ~filt_q & filt_dly_q;

`ifdef PINMUX_IN_FILTER_STATUS_EN
  logic [NMioPads-1:0] status_q;

  // A new edge in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~bus.status_clr_i) | bus.edge_rise_o | bus.edge_fall_o;
    end
  end

  assign bus.status_o = status_q;
  assign bus.irq_o    = |status_q;
`else
  logic unused_status_clr;
  assign unused_status_clr = ^bus.status_clr_i;
  assign bus.status_o      = '0;
  assign bus.irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_pinmux_in_filter.sv
// Self-checking bench for pinmux_in_filter: directed vector table, hand-written
// status / mid-count reset sequences, then random stimulus against a window-based model.
module tb_pinmux_in_filter;
  localparam int   N        = 32;
  localparam int   SYNC     = 2;
  localparam int   CW       = 4;
  localparam logic PAD_RST  = 1'b0;
`ifdef PINMUX_IN_FILTER_STATUS_EN
  localparam bit   STATUS_EN = 1'b1;
`else
  localparam bit   STATUS_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pinmux_in_filter_if #(.NMioPads(N), .FiltCntW(CW)) pif ();

  pinmux_in_filter #(
    .NMioPads(N), .SyncStages(SYNC), .FiltCntW(CW), .PadRstVal(PAD_RST)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (pif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronizer is a queue of past pad vectors; the filter
  // accepts a level when the last thresh+1 synced samples since enable all differ
  // from the current output.
  logic [N-1:0] pad_hist [$];
  logic [N-1:0] m_filt, m_filt_d, m_status;
  logic [15:0]  m_win [N];
  int           m_len [N];

  task automatic model_reset();
    pad_hist.delete();
    for (int i = 0; i < SYNC; i++) pad_hist.push_back({N{PAD_RST}});
    m_filt   = {N{PAD_RST}};
    m_filt_d = {N{PAD_RST}};
    m_status = '0;
    for (int k = 0; k < N; k++) begin
      m_win[k] = '0;
      m_len[k] = 0;
    end
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] pad, input logic [N-1:0] en,
                            input logic [CW-1:0] th, input logic [N-1:0] clr);
    logic [N-1:0] s, nf, rise, fall;
    bit           accept;
    rise = m_filt & ~m_filt_d;
    fall = ~m_filt & m_filt_d;
    if (r) begin
      model_reset();
      return;
    end
    s = pad_hist.pop_front();
    pad_hist.push_back(pad);
    nf = m_filt;
    for (int k = 0; k < N; k++) begin
      if (!en[k]) begin
        nf[k]    = s[k];
        m_len[k] = 0;
      end else begin
        m_win[k] = {m_win[k][14:0], s[k]};
        if (m_len[k] < 16) m_len[k]++;
        accept = (m_len[k] >= int'(th) + 1);
        for (int i = 0; i <= int'(th); i++)
          if (m_win[k][i] == m_filt[k]) accept = 1'b0;
        if (accept) nf[k] = s[k];
      end
    end
    m_filt_d = m_filt;
    m_filt   = nf;
    if (STATUS_EN) m_status = (m_status & ~clr) | rise | fall;
  endtask

  task automatic step(input logic r, input logic [N-1:0] pad, input logic [N-1:0] en,
                      input logic [CW-1:0] th, input logic [N-1:0] clr);
    rst_i             = r;
    pif.mio_pad_i     = pad;
    pif.filt_en_i     = en;
    pif.filt_thresh_i = th;
    pif.status_clr_i  = clr;
    @(posedge clk_i);
    model_edge(r, pad, en, th, clr);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] pad;
    logic         en;
    logic [CW-1:0] thr;
    logic [N-1:0] mio;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic [N-1:0] pad, input logic en, input logic [CW-1:0] thr,
                     input logic [N-1:0] mio, input logic [N-1:0] rise, input logic [N-1:0] fall,
                     input int reps = 1);
    for (int i = 0; i < reps; i++) tbl.push_back('{r, pad, en, thr, mio, rise, fall});
  endtask

  logic [N-1:0]  pad_r, en_r, clr_r;
  logic [CW-1:0] th_r;
  logic          rst_r;
  localparam logic [N-1:0] ALL = {N{1'b1}};

  initial begin
    model_reset();
    // Reset with pads toggling, glitch reject (4 high), accept (5+ high, thresh 4),
    // bypass fall, bypass rise on pad 3, thresh 0 behaving as bypass.
    add(1, ALL, 0, 0, 0, 0, 0);
    add(1, 0,   0, 0, 0, 0, 0);
    add(1, ALL, 0, 0, 0, 0, 0);
    add(0, 0,   1, 4, 0, 0, 0);
    add(0, 1,   1, 4, 0, 0, 0, 4);
    add(0, 0,   1, 4, 0, 0, 0, 4);
    add(0, 1,   1, 4, 0, 0, 0, 6);
    add(0, 1,   1, 4, 1, 1, 0);
    add(0, 1,   1, 4, 1, 0, 0);
    add(0, 1,   0, 4, 1, 0, 0);
    add(0, 0,   0, 4, 1, 0, 0, 2);
    add(0, 0,   0, 4, 0, 0, 1);
    add(0, 0,   0, 4, 0, 0, 0);
    add(0, 8,   0, 4, 0, 0, 0, 2);
    add(0, 8,   0, 4, 8, 8, 0);
    add(0, 0,   0, 4, 8, 0, 0);
    add(0, 0,   1, 0, 8, 0, 0);
    add(0, 0,   1, 0, 0, 0, 8);
    add(0, 0,   1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].pad, {N{tbl[i].en}}, tbl[i].thr, '0);
      check($sformatf("tbl%0d_mio", i),  pif.mio_in_o,    tbl[i].mio);
      check($sformatf("tbl%0d_rise", i), pif.edge_rise_o, tbl[i].rise);
      check($sformatf("tbl%0d_fall", i), pif.edge_fall_o, tbl[i].fall);
      if (tbl[i].rst) begin
        check($sformatf("tbl%0d_status", i), pif.status_o, '0);
        check($sformatf("tbl%0d_irq", i),    N'(pif.irq_o), '0);
      end
    end

    // Sticky status on pad 7: set, clear, set-beats-clear, clear.
    step(0, 0, 0, 4, ALL);
    step(0, 0, 0, 4, ALL);
    check("st_cleared", pif.status_o, '0);
    check("irq_cleared", N'(pif.irq_o), '0);
    repeat (3) step(0, 32'h80, 0, 4, 0);
    check("st_rise7", pif.edge_rise_o, 32'h80);
    step(0, 32'h80, 0, 4, 0);
    check("st_set", pif.status_o, STATUS_EN ? 32'h80 : 32'h0);
    check("irq_set", N'(pif.irq_o), N'(STATUS_EN));
    step(0, 32'h80, 0, 4, 32'h80);
    check("st_clr", pif.status_o, '0);
    check("irq_clr", N'(pif.irq_o), '0);
    repeat (3) step(0, 0, 0, 4, 0);
    check("st_fall7", pif.edge_fall_o, 32'h80);
    step(0, 0, 0, 4, 32'h80);
    check("st_set_wins", pif.status_o, STATUS_EN ? 32'h80 : 32'h0);
    check("irq_set_wins", N'(pif.irq_o), N'(STATUS_EN));
    step(0, 0, 0, 4, 32'h80);
    check("st_clr2", pif.status_o, '0);
    check("irq_clr2", N'(pif.irq_o), '0);

    // Reset while pad 0 count sits at 3: count must restart from zero.
    repeat (5) step(0, 1, ALL, 4, 0);
    check("mid_pre", pif.mio_in_o, '0);
    step(1, 1, ALL, 4, 0);
    check("mid_rst_mio", pif.mio_in_o, '0);
    check("mid_rst_rise", pif.edge_rise_o, '0);
    step(0, 1, ALL, 4, 0);
    check("mid_post_rise", pif.edge_rise_o, '0);
    check("mid_post_irq", N'(pif.irq_o), '0);
    repeat (5) step(0, 1, ALL, 4, 0);
    check("mid_hold", pif.mio_in_o, '0);
    step(0, 1, ALL, 4, 0);
    check("mid_accept", pif.mio_in_o, 32'h1);
    check("mid_accept_rise", pif.edge_rise_o, 32'h1);

    // Random traffic against the model.
    pad_r = '0;
    en_r  = '0;
    th_r  = '0;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0 || $urandom_range(0, 49) == 0) en_r = $urandom;
      if (c % 64 == 0 || $urandom_range(0, 49) == 0) th_r = CW'($urandom_range(0, 6));
      pad_r ^= $urandom & $urandom & $urandom;
      clr_r = ($urandom_range(0, 3) == 0) ? $urandom : '0;
      rst_r = ($urandom_range(0, 299) == 0);
      step(rst_r, pad_r, en_r, th_r, clr_r);
      check("rnd_mio",    pif.mio_in_o,    m_filt);
      check("rnd_rise",   pif.edge_rise_o, m_filt & ~m_filt_d);
      check("rnd_fall",   pif.edge_fall_o, ~m_filt & m_filt_d);
      check("rnd_status", pif.status_o,    m_status);
      check("rnd_irq",    N'(pif.irq_o),   N'(|m_status));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
